// File: rtl/mrr_loopback_push_ctrl.sv
// ---------------------------------------------------------------------------
// mrr_loopback_push_ctrl
//
// Host-side writer for the per-node loopback queue. Frames arrive on a 32-bit
// AXI-stream: one header word carrying the destination chip ID, then
// MSG_WORDS payload words, most significant word first. Each well-formed
// frame becomes one {chip_id, message} entry in a small FIFO. A pusher FSM
// drains the FIFO into the queue through the lq_push_request/lq_push_ack
// handshake, one entry at a time, with a one-cycle gap after every ack.
//
// Optional feature macro: MRR_LQ_PUSH_TIMEOUT_EN
//   defined   : a request left unacknowledged for TIMEOUT_LEN cycles is
//               abandoned and counted in err_count.
//   undefined : the pusher waits for the ack indefinitely.
//
// Reset is synchronous and active-low on the port named rst.
// ---------------------------------------------------------------------------
module mrr_loopback_push_ctrl #(
    parameter int CHIP_ID_LEN          = 24,
    parameter int LOOPBACK_MESSAGE_LEN = 64,
    parameter int FIFO_DEPTH_LOG2      = 2,
    parameter int TIMEOUT_LEN          = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    // host frame stream
    input  logic [31:0]                     s_tdata,
    input  logic                            s_tvalid,
    input  logic                            s_tlast,
    output logic                            s_tready,
    // loopback queue push port
    output logic [CHIP_ID_LEN-1:0]          lq_push_chip_id,
    output logic [LOOPBACK_MESSAGE_LEN-1:0] lq_push_message,
    output logic                            lq_push_request,
    input  logic                            lq_push_ack,
    // status
    output logic [15:0]                     push_count,
    output logic [7:0]                      err_count,
    output logic [FIFO_DEPTH_LOG2:0]        fifo_level,
    output logic                            busy
);

    localparam int MSG_WORDS  = (LOOPBACK_MESSAGE_LEN + 31) / 32;
    localparam int SHIFT_W    = MSG_WORDS * 32;
    localparam int WCNT_W     = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int ENTRY_W    = CHIP_ID_LEN + LOOPBACK_MESSAGE_LEN;

    typedef enum logic [1:0] {
        P_HDR,
        P_MSG,
        P_DROP
    } parse_state_t;

    typedef enum logic [1:0] {
        Q_IDLE,
        Q_REQ,
        Q_GAP
    } push_state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    parse_state_t              p_state, p_next;
    push_state_t               q_state, q_next;

    logic                      hs;
    logic                      final_word;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      parse_err;
    logic                      push_ok;
    logic                      push_timeout;

    logic [CHIP_ID_LEN-1:0]    chip_id_q;
    logic [WCNT_W-1:0]         word_cnt;
    logic [SHIFT_W-1:0]        msg_shift;
    logic [SHIFT_W-1:0]        msg_next;

    logic [ENTRY_W-1:0]        fifo_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2:0]  wr_ptr;
    logic [FIFO_DEPTH_LOG2:0]  rd_ptr;
    logic [ENTRY_W-1:0]        fifo_head;

    logic [8:0]                err_sum;

    // ------------------------------------------------------------------
    // Stream-side helpers
    // ------------------------------------------------------------------
    assign hs         = s_tvalid & s_tready;
    assign final_word = (p_state == P_MSG) && (word_cnt == WCNT_W'(MSG_WORDS - 1));
    assign msg_next   = (msg_shift << 32) | SHIFT_W'(s_tdata);

    // A full FIFO stalls only the word that would complete an entry; a pop
    // in the same cycle frees the slot, so the word is taken right away.
    assign s_tready   = !(final_word && fifo_full && !fifo_pop);

    // ------------------------------------------------------------------
    // Parser: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking (=) here would create ordering races.
    always_ff @(posedge clk) begin
        if (!rst) p_state <= P_HDR;
        else      p_state <= p_next;
    end

    // Parser: next state, FIFO write strobe and malformed-frame flag
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        p_next    = p_state;
        fifo_push = 1'b0;
        parse_err = 1'b0;
        unique case (p_state)
            P_HDR: begin
                if (hs) begin
                    if (s_tlast) parse_err = 1'b1;      // header-only frame
                    else         p_next    = P_MSG;
                end
            end
            P_MSG: begin
                if (hs) begin
                    if (final_word) begin
                        if (s_tlast) begin
                            fifo_push = 1'b1;
                            p_next    = P_HDR;
                        end else begin
                            parse_err = 1'b1;           // frame too long
                            p_next    = P_DROP;
                        end
                    end else if (s_tlast) begin
                        parse_err = 1'b1;               // frame too short
                        p_next    = P_HDR;
                    end
                end
            end
            P_DROP: begin
                if (hs && s_tlast) p_next = P_HDR;
            end
            default: p_next = P_HDR;
        endcase
    end

    // Parser: latch chip ID from the header, shift payload words in
    always_ff @(posedge clk) begin
        if (!rst) begin
            chip_id_q <= '0;
            word_cnt  <= '0;
            msg_shift <= '0;
        end else if (hs) begin
            if (p_state == P_HDR) begin
                chip_id_q <= s_tdata[CHIP_ID_LEN-1:0];
                word_cnt  <= '0;
            end else if (p_state == P_MSG) begin
                msg_shift <= msg_next;
                word_cnt  <= word_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry FIFO (pointers carry one wrap bit to tell full from empty)
    // ------------------------------------------------------------------
    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_level == (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign fifo_head  = fifo_mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage write
    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which slots hold valid data, and an unreset array stays a plain
    // RAM instead of a bank of resettable flops.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= {chip_id_q, msg_next[LOOPBACK_MESSAGE_LEN-1:0]};
    end

    // ------------------------------------------------------------------
    // Pusher: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) q_state <= Q_IDLE;
        else      q_state <= q_next;
    end

`ifdef MRR_LQ_PUSH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_LEN + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_expired;

    assign to_expired = (to_cnt == TO_W'(TIMEOUT_LEN - 1));

    // Timeout counter: counts request cycles, restarts on every new request
    always_ff @(posedge clk) begin
        if (!rst || q_state != Q_REQ) to_cnt <= '0;
        else                          to_cnt <= to_cnt + 1'b1;
    end
`endif

    // Pusher: next state, FIFO pop, ack / timeout outcome
    always_comb begin
        q_next       = q_state;
        fifo_pop     = 1'b0;
        push_ok      = 1'b0;
        push_timeout = 1'b0;
        unique case (q_state)
            Q_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    q_next   = Q_REQ;
                end
            end
            Q_REQ: begin
                if (lq_push_ack) begin
                    push_ok = 1'b1;                     // ack wins over expiry
                    q_next  = Q_GAP;
                end
`ifdef MRR_LQ_PUSH_TIMEOUT_EN
                else if (to_expired) begin
                    push_timeout = 1'b1;
                    q_next       = Q_GAP;
                end
`endif
            end
            Q_GAP:   q_next = Q_IDLE;
            default: q_next = Q_IDLE;
        endcase
    end

    // Output registers: the head entry is captured as it is popped and held
    // stable for the whole request
    always_ff @(posedge clk) begin
        if (!rst) begin
            lq_push_chip_id <= '0;
            lq_push_message <= '0;
        end else if (fifo_pop) begin
            lq_push_chip_id <= fifo_head[ENTRY_W-1 -: CHIP_ID_LEN];
            lq_push_message <= fifo_head[LOOPBACK_MESSAGE_LEN-1:0];
        end
    end

    assign lq_push_request = (q_state == Q_REQ);

    // ------------------------------------------------------------------
    // Status counters (saturating); a parse error and a timeout can land
    // in the same cycle, so the error counter may advance by two
    // ------------------------------------------------------------------
    assign err_sum = {1'b0, err_count} + 9'(parse_err) + 9'(push_timeout);

    // Saturating push and error counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            push_count <= '0;
            err_count  <= '0;
        end else begin
            if (push_ok && push_count != 16'hFFFF) push_count <= push_count + 1'b1;
            err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign busy = (p_state != P_HDR) || !fifo_empty || lq_push_request;

endmodule

// File: tb/tb_mrr_loopback_push_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mrr_loopback_push_ctrl
//
// Directed bench for mrr_loopback_push_ctrl at default parameters
// (24-bit chip ID, 64-bit message, 4-entry FIFO, timeout feature off).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mrr_loopback_push_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [23:0] lq_push_chip_id;
    logic [63:0] lq_push_message;
    logic        lq_push_request;
    logic        lq_push_ack;
    logic [15:0] push_count;
    logic [7:0]  err_count;
    logic [2:0]  fifo_level;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    mrr_loopback_push_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tlast         (s_tlast),
        .s_tready        (s_tready),
        .lq_push_chip_id (lq_push_chip_id),
        .lq_push_message (lq_push_message),
        .lq_push_request (lq_push_request),
        .lq_push_ack     (lq_push_ack),
        .push_count      (push_count),
        .err_count       (err_count),
        .fifo_level      (fifo_level),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Called on a falling edge; presents one word, waits (bounded) for
    // s_tready, lets the rising edge take it and returns on the next fall.
    task automatic send_word(input logic [31:0] data, input logic last);
        int waited = 0;
        s_tdata  = data;
        s_tvalid = 1'b1;
        s_tlast  = last;
        while (!s_tready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!s_tready) check("tready_wait", s_tready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] chip, input logic [63:0] msg);
        send_word({8'h5A, chip}, 1'b0);
        send_word(msg[63:32], 1'b0);
        send_word(msg[31:0], 1'b1);
    endtask

    // Waits (bounded) for a request, checks the presented entry, acks it for
    // one cycle and checks that the request has dropped.
    task automatic ack_expect(input string tag, input logic [23:0] chip, input logic [63:0] msg);
        int waited = 0;
        while (!lq_push_request && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_req"}, lq_push_request, 1'b1);
        check({tag, "_chip"}, lq_push_chip_id, chip);
        check({tag, "_msg"}, lq_push_message, msg);
        lq_push_ack = 1'b1;
        @(negedge clk);
        lq_push_ack = 1'b0;
        check({tag, "_req_drop"}, lq_push_request, 1'b0);
    endtask

    function automatic logic [23:0] fchip(input int i);
        return 24'h100000 + 24'(i);
    endfunction

    function automatic logic [63:0] fmsg(input int i);
        return {32'hA0000000 + 32'(i), 32'hB0000000 + 32'(i)};
    endfunction

    initial begin
        rst         = 1'b0;
        s_tdata     = '0;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        lq_push_ack = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- reset state ----------------
        check("rst_tready", s_tready, 1'b1);
        check("rst_req", lq_push_request, 1'b0);
        check("rst_push_cnt", push_count, 16'd0);
        check("rst_err_cnt", err_count, 8'd0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_chip", lq_push_chip_id, 24'd0);
        check("rst_msg", lq_push_message, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // ---------------- single frame, latency ----------------
        send_word(32'h77ABCDEF, 1'b0);
        send_word(32'h11223344, 1'b0);
        send_word(32'h55667788, 1'b1);
        check("t1_level_c1", fifo_level, 3'd1);
        check("t1_req_c1", lq_push_request, 1'b0);
        @(negedge clk);
        check("t1_req_c2", lq_push_request, 1'b1);
        check("t1_level_c2", fifo_level, 3'd0);
        check("t1_busy", busy, 1'b1);
        ack_expect("t1", 24'hABCDEF, 64'h1122334455667788);
        check("t1_push_cnt", push_count, 16'd1);

        // stray ack while idle is ignored
        @(negedge clk);
        lq_push_ack = 1'b1;
        @(negedge clk);
        lq_push_ack = 1'b0;
        check("stray_ack_cnt", push_count, 16'd1);
        check("stray_ack_req", lq_push_request, 1'b0);

        // ---------------- short frames ----------------
        send_word(32'h00000042, 1'b0);
        check("t2_tready", s_tready, 1'b1);
        send_word(32'hDEADDEAD, 1'b1);
        check("t2_err", err_count, 8'd1);
        check("t2_tready_after", s_tready, 1'b1);
        send_word(32'h00000043, 1'b1);
        check("t2_hdr_only_err", err_count, 8'd2);
        repeat (3) @(negedge clk);
        check("t2_no_req", lq_push_request, 1'b0);
        check("t2_level", fifo_level, 3'd0);

        // ---------------- long frame, then a good one ----------------
        send_word(32'h00000044, 1'b0);
        send_word(32'h01010101, 1'b0);
        send_word(32'h02020202, 1'b0);
        check("t3_err", err_count, 8'd3);
        send_word(32'h03030303, 1'b1);
        check("t3_level", fifo_level, 3'd0);
        check("t3_busy", busy, 1'b0);
        send_frame(24'h000123, 64'hDEADBEEFCAFEF00D);
        ack_expect("t3", 24'h000123, 64'hDEADBEEFCAFEF00D);
        check("t3_push_cnt", push_count, 16'd2);

        // ---------------- FIFO fill with ack held low ----------------
        for (int i = 1; i <= 5; i++) send_frame(fchip(i), fmsg(i));
        check("t4_level_full", fifo_level, 3'd4);
        check("t4_req_head", lq_push_chip_id, fchip(1));
        send_word({8'h00, fchip(6)}, 1'b0);
        send_word(fmsg(6)[63:32], 1'b0);
        s_tdata  = fmsg(6)[31:0];
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        check("t4_stall_tready", s_tready, 1'b0);
        @(negedge clk);
        check("t4_stall_tready_hold", s_tready, 1'b0);
        check("t4_stall_level", fifo_level, 3'd4);
        ack_expect("t4_f1", fchip(1), fmsg(1));
        send_word(fmsg(6)[31:0], 1'b1);
        check("t4_level_after", fifo_level, 3'd4);
        for (int i = 2; i <= 6; i++) ack_expect($sformatf("t4_f%0d", i), fchip(i), fmsg(i));
        check("t4_push_cnt", push_count, 16'd8);
        check("t4_level_empty", fifo_level, 3'd0);
        check("t4_busy_idle", busy, 1'b0);

        // ---------------- reset mid-request ----------------
        for (int i = 7; i <= 9; i++) send_frame(fchip(i), fmsg(i));
        check("t5_level", fifo_level, 3'd2);
        check("t5_req", lq_push_request, 1'b1);
        send_word(32'h00FFFFFF, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_req_low", lq_push_request, 1'b0);
        check("t5_level_0", fifo_level, 3'd0);
        check("t5_push_0", push_count, 16'd0);
        check("t5_err_0", err_count, 8'd0);
        check("t5_busy_0", busy, 1'b0);
        check("t5_tready", s_tready, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        send_frame(fchip(10), fmsg(10));
        ack_expect("t5_f10", fchip(10), fmsg(10));
        check("t5_push_1", push_count, 16'd1);
        check("t5_err_still_0", err_count, 8'd0);

        // ---------------- error counter saturation ----------------
        for (int i = 0; i < 260; i++) send_word(32'(i), 1'b1);
        check("sat_err", err_count, 8'hFF);
        check("sat_level", fifo_level, 3'd0);
        check("sat_req", lq_push_request, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
